// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: default widths, PC stepping constants and
// the {pc, instr} record carried through the fetch queue.
package riscv_pkg;

  localparam int INS_ADDRESS = 9;
  localparam int INS_W       = 32;
  localparam int PC_STEP     = 4;
  localparam int RESET_PC    = 0;

  typedef struct packed {
    logic [INS_ADDRESS-1:0] pc;
    logic [INS_W-1:0]       instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous in-order FIFO with flush. The head is read straight out of
// storage, so an empty queue keeps showing whatever the read slot last held.
module fetch_queue #(
  parameter int DATA_W = 41,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_head,
  output logic              o_empty,
  output logic              o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_head  = r_mem[r_rd_ptr];

  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory combinationally
// and queues {pc, instr} for decode; redirects flush the queue and reload the PC.
module fetch_unit #(
  parameter int INS_ADDRESS = riscv_pkg::INS_ADDRESS,
  parameter int INS_W       = riscv_pkg::INS_W,
  parameter int FQ_DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_en,
  input  logic                   redirect_valid,
  input  logic [INS_ADDRESS-1:0] redirect_pc,
  output logic [INS_ADDRESS-1:0] imem_ra,
  input  logic [INS_W-1:0]       imem_rd,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [INS_W-1:0]       if_instr,
  output logic [INS_ADDRESS-1:0] if_pc,
  output logic [INS_ADDRESS-1:0] if_pc_plus4
);

  import riscv_pkg::*;

  localparam int EW = INS_ADDRESS + INS_W;

  logic [INS_ADDRESS-1:0] r_pc;
  logic [INS_ADDRESS-1:0] w_pc_next;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_empty;
  logic                   w_full;
  logic [EW-1:0]          w_head;

  // Decode handshake: an entry transfers on every rising edge where if_valid
  // and if_ready are both high; if_* stay frozen while valid is held without
  // ready, except across a redirect or reset.
  assign if_valid = ~w_empty;
  assign w_pop    = if_valid & if_ready;
  assign w_push   = fetch_en & ~redirect_valid & (~w_full | w_pop);

  assign imem_ra = r_pc;

  always_comb begin
    w_pc_next = r_pc;
    if (redirect_valid) begin
      w_pc_next = {redirect_pc[INS_ADDRESS-1:2], 2'b00};
    end else if (w_push) begin
      w_pc_next = r_pc + INS_ADDRESS'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= INS_ADDRESS'(RESET_PC);
    end else begin
      r_pc <= w_pc_next;
    end
  end

  fetch_queue #(
    .DATA_W (EW),
    .DEPTH  (FQ_DEPTH)
  ) u_fetch_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  ({r_pc, imem_rd}),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign if_pc       = w_head[EW-1:INS_W];
  assign if_instr    = w_head[INS_W-1:0];
  assign if_pc_plus4 = if_pc + INS_ADDRESS'(PC_STEP);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, checked against
// a queue-level reference model of the fetch stream.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int AW    = 9;
  localparam int IW    = 32;
  localparam int DEPTH = 2;
  localparam int EW    = $bits(fetch_entry_t);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fetch_en = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] imem_ra;
  logic [IW-1:0] imem_rd;
  logic          if_valid;
  logic          if_ready = 1'b0;
  logic [IW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic [AW-1:0] if_pc_plus4;

  int n_cmp = 0;
  int n_err = 0;
  int n_retired = 0;

  logic [EW-1:0] exp_q[$];
  int            m_pc = 0;
  bit            m_rst = 1'b0;

  always #5 clk = ~clk;

  assign imem_rd = 32'hA500_0000 | 32'(imem_ra);

  fetch_unit #(
    .INS_ADDRESS (AW),
    .INS_W       (IW),
    .FQ_DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_ra        (imem_ra),
    .imem_rd        (imem_rd),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the program stream at the instruction level.
  // Dequeue on acceptance is done by the monitor just before the edge.
  always @(posedge clk) begin
    fetch_entry_t e;
    if (reset) begin
      m_pc  = 0;
      m_rst = 1'b1;
      exp_q.delete();
    end else begin
      m_rst = 1'b0;
      if (redirect_valid) begin
        exp_q.delete();
        m_pc = (int'(redirect_pc) / 4) * 4;
      end else if (fetch_en && exp_q.size() < DEPTH) begin
        e.pc    = AW'(m_pc);
        e.instr = 32'hA500_0000 + 32'(m_pc);
        exp_q.push_back(e);
        m_pc = (m_pc + 4) % 512;
      end
    end
  end

  // Monitor: compares the visible head against the oldest expected entry and
  // retires it when decode accepts.
  always @(negedge clk) begin
    fetch_entry_t e;
    check("imem_ra", 64'(imem_ra), 64'(m_pc));
    check("if_valid", 64'(if_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check("if_pc", 64'(if_pc), 64'(e.pc));
      check("if_instr", 64'(if_instr), 64'(e.instr));
      check("if_pc_plus4", 64'(if_pc_plus4), 64'((int'(e.pc) + 4) % 512));
      if (if_ready && !reset) begin
        void'(exp_q.pop_front());
        n_retired++;
      end
    end else if (m_rst) begin
      check("rst_if_pc", 64'(if_pc), 64'd0);
      check("rst_if_instr", 64'(if_instr), 64'd0);
      check("rst_if_pc_plus4", 64'(if_pc_plus4), 64'd4);
    end
  end

  task automatic drive(input bit r, input bit fe, input bit rv, input logic [AW-1:0] rp,
                       input bit rdy);
    reset          = r;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rp;
    if_ready       = rdy;
    @(posedge clk);
    #3;
  endtask

  initial begin
    int base;
    repeat (2) drive(1, 0, 0, '0, 0);
    // Streaming from reset
    repeat (10) drive(0, 1, 0, '0, 1);
    // Back-pressure from pc 0, then release
    drive(1, 0, 0, '0, 0);
    repeat (5) drive(0, 1, 0, '0, 0);
    repeat (6) drive(0, 1, 0, '0, 1);
    // Redirect with a full queue, unaligned target
    repeat (3) drive(0, 1, 0, '0, 0);
    drive(0, 1, 1, 9'h043, 0);
    repeat (4) drive(0, 1, 0, '0, 1);
    // Redirect near the top of the address space to exercise wrap
    drive(0, 1, 1, 9'h1F8, 1);
    repeat (6) drive(0, 1, 0, '0, 1);
    // Full queue with simultaneous pop and push
    repeat (3) drive(0, 1, 0, '0, 0);
    base = n_retired;
    repeat (10) drive(0, 1, 0, '0, 1);
    check("sustained_retire", 64'(n_retired - base), 64'd10);
    // Mid-stream reset, restart, then drain with fetch disabled
    repeat (3) drive(0, 1, 0, '0, 0);
    drive(1, 1, 0, '0, 1);
    repeat (4) drive(0, 1, 0, '0, 1);
    repeat (2) drive(0, 1, 0, '0, 0);
    repeat (4) drive(0, 0, 0, '0, 1);
    // Random traffic
    repeat (3000) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0),
            AW'($urandom_range(0, 511)),
            ($urandom_range(0, 2) != 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
